// File: rtl/pl_hazard_scheduler.sv
// pl_hazard_scheduler: stall, flush and forwarding control for a 5-stage F/D/E/M/W pipeline.
// Keeps a shadow of the E/M/W control fields and saturating load-use / flush event counters.
module pl_hazard_scheduler #(
   parameter int CNT_W  = 16,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_D,
   input  logic [REG_AW-1:0] rs1_D,
   input  logic [REG_AW-1:0] rs2_D,
   input  logic [REG_AW-1:0] rd_D,
   input  logic              use_rs1_D,
   input  logic              use_rs2_D,
   input  logic              RegWrite_D,
   input  logic [1:0]        ResultSrc_D,
   input  logic              PCSrc_E,
   input  logic              mem_busy,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0]        RES_LOAD = 2'b01;
   localparam logic [1:0]        FWD_RF   = 2'b00;
   localparam logic [1:0]        FWD_W    = 2'b01;
   localparam logic [1:0]        FWD_M    = 2'b10;
   localparam logic [REG_AW-1:0] REG_X0   = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_ZERO + 1'b1;

   // A stage only counts as a producer of r when it really writes a non-x0 register
   function automatic logic writes_reg(input logic              vld,
                                       input logic              wr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
      return vld & wr & (rd != REG_X0) & (rd == r);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic              e_valid_r, e_regwrite_r, e_is_load_r;
   logic [REG_AW-1:0] e_rd_r, e_rs1_r, e_rs2_r;
   logic              m_valid_r, m_regwrite_r;
   logic [REG_AW-1:0] m_rd_r;
   logic              w_valid_r, w_regwrite_r;
   logic [REG_AW-1:0] w_rd_r;
   logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

   logic       load_use_s;
   logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
   logic       flush_d_s, flush_e_s;
   logic       stall_evt_s, flush_evt_s;
   logic [1:0] fwd_a_s, fwd_b_s;

   assign load_use_s = e_is_load_r & writes_reg(e_valid_r, e_regwrite_r, e_rd_r, e_rd_r) & valid_D &
                       ((use_rs1_D & (rs1_D == e_rd_r)) | (use_rs2_D & (rs2_D == e_rd_r)));

   // Hazard priority: memory freeze, then control-flow flush, then load-use bubble
   always_comb begin
      stall_f_s   = 1'b0;
      stall_d_s   = 1'b0;
      stall_e_s   = 1'b0;
      stall_m_s   = 1'b0;
      flush_d_s   = 1'b0;
      flush_e_s   = 1'b0;
      stall_evt_s = 1'b0;
      flush_evt_s = 1'b0;
      if (!rst_n) begin
         stall_f_s = 1'b0;
      end else if (mem_busy) begin
         stall_f_s = 1'b1;
         stall_d_s = 1'b1;
         stall_e_s = 1'b1;
         stall_m_s = 1'b1;
      end else if (PCSrc_E) begin
         flush_d_s   = 1'b1;
         flush_e_s   = 1'b1;
         flush_evt_s = 1'b1;
      end else if (load_use_s) begin
         stall_f_s   = 1'b1;
         stall_d_s   = 1'b1;
         flush_e_s   = 1'b1;
         stall_evt_s = 1'b1;
      end else begin
         stall_f_s = 1'b0;
      end
   end

   // Operand bypass for the instruction in E; M carries the newer value so it wins over W
   always_comb begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
      if (!rst_n || !e_valid_r) begin
         fwd_a_s = FWD_RF;
         fwd_b_s = FWD_RF;
      end else begin
         if (writes_reg(m_valid_r, m_regwrite_r, m_rd_r, e_rs1_r)) begin
            fwd_a_s = FWD_M;
         end else if (writes_reg(w_valid_r, w_regwrite_r, w_rd_r, e_rs1_r)) begin
            fwd_a_s = FWD_W;
         end else begin
            fwd_a_s = FWD_RF;
         end
         if (writes_reg(m_valid_r, m_regwrite_r, m_rd_r, e_rs2_r)) begin
            fwd_b_s = FWD_M;
         end else if (writes_reg(w_valid_r, w_regwrite_r, w_rd_r, e_rs2_r)) begin
            fwd_b_s = FWD_W;
         end else begin
            fwd_b_s = FWD_RF;
         end
      end
   end

   // Shadow pipeline advance; frozen entirely while data memory is busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_r    <= 1'b0;
         e_regwrite_r <= 1'b0;
         e_is_load_r  <= 1'b0;
         e_rd_r       <= REG_X0;
         e_rs1_r      <= REG_X0;
         e_rs2_r      <= REG_X0;
         m_valid_r    <= 1'b0;
         m_regwrite_r <= 1'b0;
         m_rd_r       <= REG_X0;
         w_valid_r    <= 1'b0;
         w_regwrite_r <= 1'b0;
         w_rd_r       <= REG_X0;
      end else if (!mem_busy) begin
         w_valid_r    <= m_valid_r;
         w_regwrite_r <= m_regwrite_r;
         w_rd_r       <= m_rd_r;
         m_valid_r    <= e_valid_r;
         m_regwrite_r <= e_regwrite_r;
         m_rd_r       <= e_rd_r;
         if (flush_e_s) begin
            e_valid_r    <= 1'b0;
            e_regwrite_r <= 1'b0;
            e_is_load_r  <= 1'b0;
            e_rd_r       <= REG_X0;
            e_rs1_r      <= REG_X0;
            e_rs2_r      <= REG_X0;
         end else begin
            e_valid_r    <= valid_D;
            e_regwrite_r <= RegWrite_D;
            e_is_load_r  <= (ResultSrc_D == RES_LOAD);
            e_rd_r       <= rd_D;
            e_rs1_r      <= rs1_D;
            e_rs2_r      <= rs2_D;
         end
      end
   end

   // Saturating event counters; the event flags are already masked by mem_busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= CNT_ZERO;
         flush_cnt_r <= CNT_ZERO;
      end else begin
         if (stall_evt_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (flush_evt_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
         end
      end
   end

   assign StallF    = stall_f_s;
   assign StallD    = stall_d_s;
   assign StallE    = stall_e_s;
   assign StallM    = stall_m_s;
   assign FlushD    = flush_d_s;
   assign FlushE    = flush_e_s;
   assign ForwardAE = fwd_a_s;
   assign ForwardBE = fwd_b_s;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pl_hazard_scheduler.sv
// Bench for pl_hazard_scheduler: directed vector table, reset corner cases and a
// randomized run checked against a stage-list reference model.
module tb_pl_hazard_scheduler;

   localparam int CNT_W   = 5;
   localparam int REG_AW  = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic       vd;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, rw;
      logic [1:0] rsrc;
   } instr_t;

   typedef struct {
      instr_t     d;
      logic       pc, mb;
      logic [3:0] stl;   // {StallF, StallD, StallE, StallM}
      logic [1:0] fl;    // {FlushD, FlushE}
      logic [1:0] fa, fb;
      int         sc, fc;
   } vec_t;

   typedef struct {
      logic       valid, rw, ld;
      logic [4:0] rd, rs1, rs2;
   } stage_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_D, use_rs1_D, use_rs2_D, RegWrite_D, PCSrc_E, mem_busy;
   logic [REG_AW-1:0] rs1_D, rs2_D, rd_D;
   logic [1:0]        ResultSrc_D;
   logic              StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0]        ForwardAE, ForwardBE;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pl_hazard_scheduler #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .RegWrite_D(RegWrite_D),
      .ResultSrc_D(ResultSrc_D), .PCSrc_E(PCSrc_E), .mem_busy(mem_busy),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic instr_t alu(input int rd, input int rs1, input int rs2);
      instr_t i;
      i.vd = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1; i.rsrc = 2'b00;
      return i;
   endfunction

   function automatic instr_t imm(input int rd, input int rs1);
      instr_t i;
      i = alu(rd, rs1, 0);
      i.u2 = 1'b0;
      return i;
   endfunction

   function automatic instr_t ld(input int rd, input int rs1);
      instr_t i;
      i = imm(rd, rs1);
      i.rsrc = 2'b01;
      return i;
   endfunction

   function automatic instr_t nop();
      instr_t i;
      i = alu(0, 0, 0);
      i.vd = 1'b0; i.u1 = 1'b0; i.u2 = 1'b0; i.rw = 1'b0;
      return i;
   endfunction

   function automatic vec_t mk(input instr_t d, input logic pc, input logic mb, input logic [3:0] stl,
                               input logic [1:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                               input int sc, input int fc);
      vec_t v;
      v.d = d; v.pc = pc; v.mb = mb; v.stl = stl; v.fl = fl; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   task automatic apply(input instr_t i, input logic pc, input logic mb);
      valid_D = i.vd; rs1_D = i.rs1; rs2_D = i.rs2; rd_D = i.rd;
      use_rs1_D = i.u1; use_rs2_D = i.u2; RegWrite_D = i.rw; ResultSrc_D = i.rsrc;
      PCSrc_E = pc; mem_busy = mb;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] stl, input logic [1:0] fl,
                            input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
      check({tag, "/stall"},     32'({StallF, StallD, StallE, StallM}), 32'(stl));
      check({tag, "/flush"},     32'({FlushD, FlushE}), 32'(fl));
      check({tag, "/ForwardAE"}, 32'(ForwardAE), 32'(fa));
      check({tag, "/ForwardBE"}, 32'(ForwardBE), 32'(fb));
      check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(sc));
      check({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(fc));
   endtask

   // Reference model: a list of in-flight instructions E/M/W, advanced by the pipeline rules
   stage_t pipe[3];
   int     m_sc, m_fc;

   function automatic logic writes(input stage_t s, input logic [4:0] r);
      return s.valid && s.rw && (s.rd != 5'd0) && (s.rd == r);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         pipe[k] = '{valid: 1'b0, rw: 1'b0, ld: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
      end
      m_sc = 0;
      m_fc = 0;
   endtask

   task automatic model_cycle(input string tag, input instr_t d, input logic pc, input logic mb);
      logic       lu;
      logic [3:0] stl;
      logic [1:0] fl, fa, fb;
      lu = pipe[0].ld && writes(pipe[0], pipe[0].rd) && d.vd &&
           ((d.u1 && d.rs1 == pipe[0].rd) || (d.u2 && d.rs2 == pipe[0].rd));
      stl = 4'b0000; fl = 2'b00;
      if (mb)      stl = 4'b1111;
      else if (pc) fl = 2'b11;
      else if (lu) begin stl = 4'b1100; fl = 2'b01; end
      fa = 2'd0; fb = 2'd0;
      if (pipe[0].valid) begin
         fa = writes(pipe[1], pipe[0].rs1) ? 2'd2 : (writes(pipe[2], pipe[0].rs1) ? 2'd1 : 2'd0);
         fb = writes(pipe[1], pipe[0].rs2) ? 2'd2 : (writes(pipe[2], pipe[0].rs2) ? 2'd1 : 2'd0);
      end
      check_all(tag, stl, fl, fa, fb, m_sc, m_fc);
      if (!mb) begin
         if (pc)      m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
         else if (lu) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (pc || lu) pipe[0].valid = 1'b0;
         else pipe[0] = '{valid: d.vd, rw: d.rw, ld: (d.rsrc == 2'b01), rd: d.rd, rs1: d.rs1, rs2: d.rs2};
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   tbl[$];
      instr_t ri;
      logic   rpc, rmb;

      tbl.push_back(mk(alu(5, 1, 2),   1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0));
      tbl.push_back(mk(alu(7, 5, 1),   1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0));
      tbl.push_back(mk(alu(11, 3, 5),  1'b0, 1'b0, 4'b0000, 2'b00, 2'd2, 2'd0, 0, 0));
      tbl.push_back(mk(ld(6, 2),       1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd1, 0, 0));
      tbl.push_back(mk(alu(8, 2, 6),   1'b0, 1'b0, 4'b1100, 2'b01, 2'd0, 2'd0, 0, 0));
      tbl.push_back(mk(alu(8, 2, 6),   1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 0));
      tbl.push_back(mk(nop(),          1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd1, 1, 0));
      tbl.push_back(mk(ld(12, 3),      1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 0));
      tbl.push_back(mk(alu(13, 12, 12),1'b1, 1'b0, 4'b0000, 2'b11, 2'd0, 2'd0, 1, 0));
      tbl.push_back(mk(nop(),          1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(imm(0, 0),      1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(alu(14, 0, 0),  1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(nop(),          1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(ld(15, 1),      1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 1, 1));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(alu(16, 15, 1), 1'b0, 1'b1, 4'b1111, 2'b00, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(alu(16, 15, 1), 1'b0, 1'b0, 4'b1100, 2'b01, 2'd0, 2'd0, 1, 1));
      tbl.push_back(mk(alu(16, 15, 1), 1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2, 1));
      tbl.push_back(mk(nop(),          1'b0, 1'b0, 4'b0000, 2'b00, 2'd1, 2'd0, 2, 1));
      tbl.push_back(mk(nop(),          1'b1, 1'b1, 4'b1111, 2'b00, 2'd0, 2'd0, 2, 1));
      tbl.push_back(mk(nop(),          1'b1, 1'b0, 4'b0000, 2'b11, 2'd0, 2'd0, 2, 1));
      tbl.push_back(mk(nop(),          1'b0, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2, 2));

      // Reset held with hostile inputs: everything must read 0
      rst_n = 1'b0;
      apply(ld(6, 2), 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      #2 check_all("reset_busy", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);
      apply(alu(8, 2, 6), 1'b1, 1'b0);
      #1 check_all("reset_pc", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(nop(), 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         apply(tbl[i].d, tbl[i].pc, tbl[i].mb);
         #2 check_all($sformatf("row%0d", i), tbl[i].stl, tbl[i].fl, tbl[i].fa, tbl[i].fb,
                      tbl[i].sc, tbl[i].fc);
      end

      // Randomized run against the reference model; counters reach saturation
      @(negedge clk);
      rst_n = 1'b0;
      apply(nop(), 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ri.vd   = ($urandom_range(0, 7) != 0);
         ri.rs1  = 5'($urandom_range(0, 3));
         ri.rs2  = 5'($urandom_range(0, 3));
         ri.rd   = 5'($urandom_range(0, 3));
         ri.u1   = 1'($urandom_range(0, 1));
         ri.u2   = 1'($urandom_range(0, 1));
         ri.rw   = 1'($urandom_range(0, 1));
         ri.rsrc = 2'($urandom_range(0, 3));
         rpc     = ($urandom_range(0, 9) == 0);
         rmb     = ($urandom_range(0, 6) == 0);
         apply(ri, rpc, rmb);
         #2 model_cycle($sformatf("rand%0d", c), ri, rpc, rmb);
      end

      // Reset asserted in the middle of a load-use stall
      @(negedge clk);
      rst_n = 1'b0;
      apply(nop(), 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      apply(ld(6, 2), 1'b0, 1'b0);
      #2 check_all("ms_load", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);
      @(negedge clk);
      apply(alu(8, 2, 6), 1'b0, 1'b0);
      #2 check_all("ms_stall", 4'b1100, 2'b01, 2'd0, 2'd0, 0, 0);
      #1 rst_n = 1'b0;
      #1 check_all("ms_rst", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #2 check_all("ms_post", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);
      @(negedge clk);
      apply(nop(), 1'b0, 1'b0);
      #2 check_all("ms_post2", 4'b0000, 2'b00, 2'd0, 2'd0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
